// File: rtl/bpfvm_dispatcher.sv
// Round-robin dispatcher sharing one snooper and one forwarder across a bank of bpfvm instances.
// Each side independently locks one VM for a whole packet and counts completed packets.
module bpfvm_dispatcher #(
    parameter int NUM_VMS    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [ADDR_WIDTH-1:0]        snooper_wr_addr,
    input  logic [31:0]                  snooper_wr_data,
    input  logic                         snooper_wr_en,
    input  logic                         snooper_done,
    output logic                         ready_for_snooper,

    input  logic [ADDR_WIDTH-1:0]        forwarder_rd_addr,
    input  logic                         forwarder_rd_en,
    input  logic                         forwarder_done,
    output logic [63:0]                  forwarder_rd_data,
    output logic                         ready_for_forwarder,

    output logic [ADDR_WIDTH-1:0]        vm_snooper_wr_addr,
    output logic [31:0]                  vm_snooper_wr_data,
    output logic [NUM_VMS-1:0]           vm_snooper_wr_en,
    output logic [NUM_VMS-1:0]           vm_snooper_done,
    input  logic [NUM_VMS-1:0]           vm_ready_for_snooper,
    output logic [ADDR_WIDTH-1:0]        vm_forwarder_rd_addr,
    output logic [NUM_VMS-1:0]           vm_forwarder_rd_en,
    output logic [NUM_VMS-1:0]           vm_forwarder_done,
    input  logic [NUM_VMS*64-1:0]        vm_forwarder_rd_data,
    input  logic [NUM_VMS-1:0]           vm_ready_for_forwarder,

    output logic [$clog2(NUM_VMS)-1:0]   snoop_sel,
    output logic [$clog2(NUM_VMS)-1:0]   fwd_sel,
    output logic [CNT_WIDTH-1:0]         pkts_in,
    output logic [CNT_WIDTH-1:0]         pkts_out
);

    localparam int SEL_W = $clog2(NUM_VMS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // First requester after 'last', wrapping; result is unused when req is empty.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_VMS-1:0] req,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_VMS; i++) begin
            cand = SEL_W'((int'(last) + i) % NUM_VMS);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t               r_snp_state, w_snp_next;
    state_t               r_fwd_state, w_fwd_next;
    logic [SEL_W-1:0]     r_snp_sel, r_snp_last, w_snp_grant;
    logic [SEL_W-1:0]     r_fwd_sel, r_fwd_last, w_fwd_grant;
    logic [CNT_WIDTH-1:0] r_pkts_in, r_pkts_out;
    logic                 w_snp_lock, w_fwd_lock;
    logic [NUM_VMS-1:0]   w_snp_onehot, w_fwd_onehot;
    logic [63:0]          w_vm_rd [NUM_VMS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snp_state <= ST_IDLE;
            r_fwd_state <= ST_IDLE;
        end else begin
            r_snp_state <= w_snp_next;
            r_fwd_state <= w_fwd_next;
        end
    end

    always_comb begin
        w_snp_next   = r_snp_state;
        w_fwd_next   = r_fwd_state;
        w_snp_lock   = 1'b0;
        w_fwd_lock   = 1'b0;
        w_snp_grant  = rr_pick(vm_ready_for_snooper, r_snp_last);
        w_fwd_grant  = rr_pick(vm_ready_for_forwarder, r_fwd_last);
        w_snp_onehot = NUM_VMS'(1) << r_snp_sel;
        w_fwd_onehot = NUM_VMS'(1) << r_fwd_sel;
        case (r_snp_state)
            ST_IDLE: if (|vm_ready_for_snooper) w_snp_next = ST_LOCK;
            ST_LOCK: begin
                w_snp_lock = 1'b1;
                if (snooper_done) w_snp_next = ST_IDLE;
            end
            default: w_snp_next = ST_IDLE;
        endcase
        case (r_fwd_state)
            ST_IDLE: if (|vm_ready_for_forwarder) w_fwd_next = ST_LOCK;
            ST_LOCK: begin
                w_fwd_lock = 1'b1;
                if (forwarder_done) w_fwd_next = ST_IDLE;
            end
            default: w_fwd_next = ST_IDLE;
        endcase
    end

    // Pointers start at the last VM so VM0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snp_sel  <= '0;
            r_fwd_sel  <= '0;
            r_snp_last <= SEL_W'(NUM_VMS - 1);
            r_fwd_last <= SEL_W'(NUM_VMS - 1);
            r_pkts_in  <= '0;
            r_pkts_out <= '0;
        end else begin
            if (r_snp_state == ST_IDLE && |vm_ready_for_snooper) begin
                r_snp_sel  <= w_snp_grant;
                r_snp_last <= w_snp_grant;
            end
            if (r_fwd_state == ST_IDLE && |vm_ready_for_forwarder) begin
                r_fwd_sel  <= w_fwd_grant;
                r_fwd_last <= w_fwd_grant;
            end
            if (w_snp_lock && snooper_done)   r_pkts_in  <= r_pkts_in + CNT_WIDTH'(1);
            if (w_fwd_lock && forwarder_done) r_pkts_out <= r_pkts_out + CNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < NUM_VMS; g++) begin : g_rd_slice
        assign w_vm_rd[g] = vm_forwarder_rd_data[g*64 +: 64];
    end

    // The select is held after release so a read issued in the done cycle still returns the right VM.
    assign forwarder_rd_data    = w_vm_rd[r_fwd_sel];

    assign ready_for_snooper    = w_snp_lock;
    assign ready_for_forwarder  = w_fwd_lock;
    assign vm_snooper_wr_addr   = snooper_wr_addr;
    assign vm_snooper_wr_data   = snooper_wr_data;
    assign vm_forwarder_rd_addr = forwarder_rd_addr;
    assign vm_snooper_wr_en     = (w_snp_lock && snooper_wr_en)   ? w_snp_onehot : '0;
    assign vm_snooper_done      = (w_snp_lock && snooper_done)    ? w_snp_onehot : '0;
    assign vm_forwarder_rd_en   = (w_fwd_lock && forwarder_rd_en) ? w_fwd_onehot : '0;
    assign vm_forwarder_done    = (w_fwd_lock && forwarder_done)  ? w_fwd_onehot : '0;
    assign snoop_sel            = r_snp_sel;
    assign fwd_sel              = r_fwd_sel;
    assign pkts_in              = r_pkts_in;
    assign pkts_out             = r_pkts_out;

endmodule
